stream_join_dynamic_collect: RTL and testbench

- Collects the per-output response handshakes of a dynamic stream fork and merges them into one output handshake per fork transaction.
- A mask stream carries the same selection bitmask that was given to the fork. Masks are queued in an internal FIFO.
- For the mask at the head of the FIFO, each selected input handshakes exactly once, in any order and at any time. Once all selected inputs have handshaked, one output handshake is emitted and carries the OR of the collected error bits.

---
 rtl/stream_join_dynamic_collect.sv | 117 +++++++++++
 tb/tb_stream_join_dynamic_collect.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_join_dynamic_collect.sv
`default_nettype none
// ============================================================================
// Module      : stream_join_dynamic_collect
// Description : Merges the per-output responses of a dynamic stream fork into
//               one handshake per transaction, with the collected errors ORed.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_join_dynamic_collect #(
    parameter int N_INP      = 1,
    parameter int MASK_DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_INP-1:0] sel_i,
    input  logic             sel_valid_i,
    output logic             sel_ready_o,
    input  logic [N_INP-1:0] valid_i,
    output logic [N_INP-1:0] ready_o,
    input  logic [N_INP-1:0] err_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             err_o
);

    localparam int c_CNT_W = $clog2(MASK_DEPTH + 1);
    localparam int c_PTR_W = (MASK_DEPTH > 1) ? $clog2(MASK_DEPTH) : 1;
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(MASK_DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(MASK_DEPTH);

    logic [N_INP-1:0]   r_mem [MASK_DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic [N_INP-1:0]   r_done;
    logic               r_err_acc;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_complete;
    logic [N_INP-1:0]   w_head;
    logic [N_INP-1:0]   w_pending;
    logic [N_INP-1:0]   w_in_hs;

    function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_CNT_FULL);
    assign w_head    = r_mem[r_rptr];
    assign w_pending = w_empty ? '0 : (w_head & ~r_done);

    // Completion is judged on registered state only, so valid_i never reaches valid_o.
    assign w_complete = !w_empty && (w_pending == '0);

    assign sel_ready_o = !w_full;
    assign ready_o     = w_pending;
    assign valid_o     = w_complete;
    assign err_o       = w_complete & r_err_acc;

    assign w_push  = sel_valid_i && !w_full;
    assign w_pop   = w_complete && ready_i;
    assign w_in_hs = valid_i & w_pending;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MASK_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_done    <= '0;
            r_err_acc <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= sel_i;
                r_wptr        <= f_next(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_next(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // No input can be ready in a pop cycle, so clearing never loses a handshake.
            if (w_pop) begin
                r_done    <= '0;
                r_err_acc <= 1'b0;
            end else begin
                r_done    <= r_done | w_in_hs;
                r_err_acc <= r_err_acc | (|(w_in_hs & err_i));
            end
        end
    end

`ifndef SYNTHESIS
    a_params: assert property (@(posedge clk_i) (N_INP >= 1) && (MASK_DEPTH >= 1))
        else $error("stream_join_dynamic_collect: illegal parameters");

    a_sel_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (sel_valid_i && !sel_ready_o) |=> $stable(sel_i))
        else $error("stream_join_dynamic_collect: sel_i changed while stalled");

    for (genvar g = 0; g < N_INP; g++) begin : g_valid_hold
        a_valid_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (valid_i[g] && !ready_o[g]) |=> valid_i[g])
            else $error("stream_join_dynamic_collect: valid_i dropped without handshake");
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_join_dynamic_collect.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_join_dynamic_collect
// Description : Scenario-driven bench with an output-error scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_join_dynamic_collect;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] sel;
    logic         sel_valid;
    logic         sel_ready;
    logic [N-1:0] valid_in;
    logic [N-1:0] ready_out;
    logic [N-1:0] err_in;
    logic         valid_out;
    logic         ready_in;
    logic         err_out;

    int total = 0;
    int bad   = 0;
    int n_acc [N];
    int n_out = 0;
    logic exp_q [$];

    stream_join_dynamic_collect #(.N_INP(N), .MASK_DEPTH(2)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .sel_i       (sel),
        .sel_valid_i (sel_valid),
        .sel_ready_o (sel_ready),
        .valid_i     (valid_in),
        .ready_o     (ready_out),
        .err_i       (err_in),
        .valid_o     (valid_out),
        .ready_i     (ready_in),
        .err_o       (err_out)
    );

    always #5 clk = ~clk;

    // Monitor: inputs are stable at the falling edge, so this sees the coming handshakes.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (valid_in[i] && ready_out[i]) n_acc[i]++;
            end
            if (valid_out && ready_in) begin
                n_out++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected_output actual=err%0b required=no_output", err_out);
                end else begin
                    logic e;
                    e = exp_q.pop_front();
                    if (err_out !== e) begin
                        bad++;
                        $display("FAIL sb_err_o actual=%b required=%b", err_out, e);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) n_acc[i] = 0;
        n_out = 0;
    endtask

    task automatic push_mask(input logic [N-1:0] m);
        bit done;
        done      = 1'b0;
        sel       = m;
        sel_valid = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            if (sel_ready) done = 1'b1;
            tick();
        end
        sel_valid = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL push_timeout actual=not_accepted required=accepted mask=%b", m);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sel = '0; sel_valid = 1'b0; valid_in = '0; err_in = '0; ready_in = 1'b0;
        tick(); tick();
        total++;
        if ({sel_ready, ready_out, valid_out, err_out} !== {1'b1, 4'b0000, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs actual=%b required=%b",
                     {sel_ready, ready_out, valid_out, err_out}, 7'b1000000);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_partial_select();
        clear_counts();
        push_mask(4'b0101);
        valid_in = 4'b1111; err_in = 4'b0000;
        exp_q.push_back(1'b0);
        total++;
        if (ready_out !== 4'b0101) begin
            bad++; $display("FAIL t1_ready actual=%b required=%b", ready_out, 4'b0101);
        end
        tick();
        valid_in = 4'b1010;
        total++;
        if ({valid_out, err_out, ready_out} !== {1'b1, 1'b0, 4'b0000}) begin
            bad++; $display("FAIL t1_complete actual=%b required=%b",
                            {valid_out, err_out, ready_out}, 6'b100000);
        end
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        tick(); tick();
        total++;
        if ({n_acc[0], n_acc[1], n_acc[2], n_acc[3], n_out} !== {32'd1, 32'd0, 32'd1, 32'd0, 32'd1}) begin
            bad++; $display("FAIL t1_accept_counts actual=%0d%0d%0d%0d out=%0d required=1010 out=1",
                            n_acc[0], n_acc[1], n_acc[2], n_acc[3], n_out);
        end
        // Inputs 1 and 3 can never be accepted; retire them through reset.
        rst_n = 1'b0;
        #1 valid_in = '0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ordered_collect();
        clear_counts();
        push_mask(4'b1111);
        for (int c = 1; c <= 13; c++) begin
            case (c)
                3:       valid_in = 4'b0001;
                5:       valid_in = 4'b0010;
                6:       valid_in = 4'b0100;
                9:       valid_in = 4'b1000;
                default: valid_in = 4'b0000;
            endcase
            err_in = (c == 6) ? 4'b0100 : 4'b0000;
            if (c == 9) exp_q.push_back(1'b1);
            total++;
            if (valid_out !== (c >= 10)) begin
                bad++; $display("FAIL t2_valid_c%0d actual=%b required=%b", c, valid_out, (c >= 10));
            end
            if (c >= 10) begin
                total++;
                if (err_out !== 1'b1) begin
                    bad++; $display("FAIL t2_err_c%0d actual=%b required=1", c, err_out);
                end
            end
            ready_in = (c == 13);
            tick();
        end
        ready_in = 1'b0; valid_in = '0; err_in = '0;
        total++;
        if ({valid_out, ready_out, n_out} !== {1'b0, 4'b0000, 32'd1}) begin
            bad++; $display("FAIL t2_drained actual=v%b r%b out%0d required=v0 r0000 out1",
                            valid_out, ready_out, n_out);
        end
    endtask

    task automatic test_zero_mask();
        clear_counts();
        push_mask(4'b0000);
        total++;
        if ({valid_out, err_out, ready_out} !== {1'b1, 1'b0, 4'b0000}) begin
            bad++; $display("FAIL t3_zero_mask actual=%b required=%b",
                            {valid_out, err_out, ready_out}, 6'b100000);
        end
        exp_q.push_back(1'b0);
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        total++;
        if (valid_out !== 1'b0) begin
            bad++; $display("FAIL t3_popped actual=%b required=0", valid_out);
        end
    endtask

    task automatic test_full_fifo();
        clear_counts();
        push_mask(4'b0001);
        push_mask(4'b0010);
        total++;
        if (sel_ready !== 1'b0) begin
            bad++; $display("FAIL t4_full actual=%b required=0", sel_ready);
        end
        sel = 4'b0100; sel_valid = 1'b1;
        valid_in = 4'b0001;
        tick();
        valid_in = 4'b0000;
        exp_q.push_back(1'b0);
        ready_in = 1'b1;
        total++;
        if ({sel_ready, valid_out} !== 2'b01) begin
            bad++; $display("FAIL t4_no_ready_path actual=%b required=01", {sel_ready, valid_out});
        end
        tick();
        ready_in = 1'b0;
        total++;
        if (sel_ready !== 1'b1) begin
            bad++; $display("FAIL t4_ready_after_pop actual=%b required=1", sel_ready);
        end
        tick();
        sel_valid = 1'b0;
        total++;
        if ({sel_ready, ready_out} !== {1'b0, 4'b0010}) begin
            bad++; $display("FAIL t4_third_accepted actual=%b required=%b",
                            {sel_ready, ready_out}, 5'b00010);
        end
        for (int k = 0; k < 2; k++) begin
            valid_in = (k == 0) ? 4'b0010 : 4'b0100;
            tick();
            valid_in = 4'b0000;
            exp_q.push_back(1'b0);
            ready_in = 1'b1;
            tick();
            ready_in = 1'b0;
        end
        total++;
        if ({valid_out, sel_ready, n_out} !== {1'b0, 1'b1, 32'd3}) begin
            bad++; $display("FAIL t4_drained actual=v%b s%b out%0d required=v0 s1 out3",
                            valid_out, sel_ready, n_out);
        end
    endtask

    task automatic test_back_to_back();
        bit prev_hs, hs;
        clear_counts();
        prev_hs = 1'b0;
        valid_in = 4'b0001; ready_in = 1'b1;
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
        push_mask(4'b0001);
        push_mask(4'b0001);
        for (int c = 0; c < 8; c++) begin
            hs = valid_in[0] && ready_out[0];
            if (hs && prev_hs) begin
                total++; bad++;
                $display("FAIL t5_rate actual=consecutive_hs required=gap c=%0d", c);
            end
            prev_hs = hs;
            tick();
        end
        ready_in = 1'b0;
        total++;
        if ({n_acc[0], n_out} !== {32'd2, 32'd2}) begin
            bad++; $display("FAIL t5_counts actual=in%0d out%0d required=in2 out2", n_acc[0], n_out);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL t5_sb_left actual=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_counts();
        push_mask(4'b0011);
        tick();
        valid_in = 4'b0000;
        total++;
        if (ready_out !== 4'b0010) begin
            bad++; $display("FAIL t6_partial actual=%b required=0010", ready_out);
        end
        rst_n = 1'b0;
        valid_in = 4'b0010;
        #1;
        total++;
        if ({valid_out, ready_out, sel_ready, err_out} !== {1'b0, 4'b0000, 1'b1, 1'b0}) begin
            bad++; $display("FAIL t6_async_reset actual=%b required=%b",
                            {valid_out, ready_out, sel_ready, err_out}, 7'b0000010);
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        total++;
        if ({ready_out, valid_out, n_acc[1], n_out} !== {4'b0000, 1'b0, 32'd0, 32'd0}) begin
            bad++; $display("FAIL t6_empty_after actual=r%b v%b acc%0d out%0d required=r0000 v0 acc0 out0",
                            ready_out, valid_out, n_acc[1], n_out);
        end
        push_mask(4'b0010);
        total++;
        if (ready_out !== 4'b0010) begin
            bad++; $display("FAIL t6_new_mask actual=%b required=0010", ready_out);
        end
        tick();
        valid_in = 4'b0000;
        exp_q.push_back(1'b0);
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        total++;
        if ({n_acc[1], n_out, exp_q.size()} !== {32'd1, 32'd1, 32'd0}) begin
            bad++; $display("FAIL t6_final actual=acc%0d out%0d q%0d required=acc1 out1 q0",
                            n_acc[1], n_out, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_partial_select();
        test_ordered_collect();
        test_zero_mask();
        test_full_fifo();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
